// File: rtl/temp_moving_avg.sv
// Temperature conditioning: periodic sampling, N-sample moving average, and a
// double-dabble conversion of each new average into three BCD digits.
module temp_moving_avg #(
  parameter int unsigned SAMPLE_DIV = 50000000,
  parameter int unsigned LOG2_N     = 3,
  parameter int unsigned W          = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] temperatura,
  output logic [W-1:0] avg,
  output logic         avg_valid,
  output logic         filled,
  output logic [3:0]   bcd_hund,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones,
  output logic         bcd_valid
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned SUM_W = W + LOG2_N;
  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam int unsigned IT_W  = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  logic [CNT_W-1:0]  cnt_q;
  logic [LOG2_N-1:0] wr_ptr_q;
  logic [W-1:0]      buf_q [N];
  logic [SUM_W-1:0]  sum_q;
  logic              filled_q;
  logic              cap_q;
  logic [W-1:0]      avg_q;
  logic              avg_valid_q;
  logic              tick;

  state_e            state_q, state_d;
  logic [W-1:0]      sr_q, sr_d;
  logic [11:0]       acc_q, acc_d, adj;
  logic [IT_W-1:0]   it_q, it_d;
  logic [11:0]       dig_q, dig_d;
  logic              bcd_valid_q, bcd_valid_d;

  assign tick = (cnt_q == CNT_W'(SAMPLE_DIV - 1));

  // Sample timer and circular window with a running sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      sum_q    <= '0;
      filled_q <= 1'b0;
      cap_q    <= 1'b0;
      for (int i = 0; i < int'(N); i++) buf_q[i] <= '0;
    end else begin
      cap_q <= tick;
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
        if (!filled_q) begin
          // Preload the whole window so the first average carries no warm-up bias.
          for (int i = 0; i < int'(N); i++) buf_q[i] <= temperatura;
          sum_q    <= {temperatura, {LOG2_N{1'b0}}};
          wr_ptr_q <= LOG2_N'(1);
          filled_q <= 1'b1;
        end else begin
          buf_q[wr_ptr_q] <= temperatura;
          sum_q    <= sum_q + SUM_W'(temperatura) - SUM_W'(buf_q[wr_ptr_q]);
          wr_ptr_q <= wr_ptr_q + LOG2_N'(1);
        end
      end
    end
  end

  // Average register, updated the cycle after each capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= cap_q;
      if (cap_q) avg_q <= sum_q[SUM_W-1:LOG2_N];
    end
  end

  // BCD conversion state and output digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      acc_q       <= '0;
      it_q        <= '0;
      dig_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      it_q        <= it_d;
      dig_q       <= dig_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  // Double-dabble next state; a new average restarts any conversion in progress.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    acc_d       = acc_q;
    it_d        = it_q;
    dig_d       = dig_q;
    bcd_valid_d = 1'b0;
    adj         = acc_q;
    for (int i = 0; i < 3; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    if (avg_valid_q) begin
      sr_d    = avg_q;
      acc_d   = '0;
      it_d    = '0;
      state_d = StShift;
    end else begin
      unique case (state_q)
        StIdle: ;
        StShift: begin
          {acc_d, sr_d} = {adj, sr_q} << 1;
          it_d          = it_q + IT_W'(1);
          if (it_q == IT_W'(W - 1)) state_d = StDone;
        end
        StDone: begin
          // All three digits change in the same cycle.
          dig_d       = acc_q;
          bcd_valid_d = 1'b1;
          state_d     = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign avg       = avg_q;
  assign avg_valid = avg_valid_q;
  assign filled    = filled_q;
  assign bcd_hund  = dig_q[11:8];
  assign bcd_tens  = dig_q[7:4];
  assign bcd_ones  = dig_q[3:0];
  assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_temp_moving_avg.sv
// Self-checking bench for temp_moving_avg with a short sample period.
module tb_temp_moving_avg;

  localparam int unsigned SAMPLE_DIV = 16;
  localparam int unsigned LOG2_N     = 3;
  localparam int unsigned W          = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] temperatura = '0;
  logic [W-1:0] avg;
  logic         avg_valid;
  logic         filled;
  logic [3:0]   bcd_hund;
  logic [3:0]   bcd_tens;
  logic [3:0]   bcd_ones;
  logic         bcd_valid;

  temp_moving_avg #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .LOG2_N    (LOG2_N),
    .W         (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .temperatura(temperatura),
    .avg        (avg),
    .avg_valid  (avg_valid),
    .filled     (filled),
    .bcd_hund   (bcd_hund),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .bcd_valid  (bcd_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_av = -1;
  int exp_q[$];

  // Reference window: average recomputed from scratch on every sample.
  int win[8];
  int wptr = 0;
  bit mfilled = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    mfilled = 1'b0;
    wptr    = 0;
    last_av = -1;
    exp_q.delete();
  endtask

  task automatic model_push(input int v, output int e);
    int s;
    if (!mfilled) begin
      for (int i = 0; i < 8; i++) win[i] = v;
      wptr    = 1;
      mfilled = 1'b1;
    end else begin
      win[wptr] = v;
      wptr      = (wptr + 1) % 8;
    end
    s = 0;
    for (int i = 0; i < 8; i++) s += win[i];
    e = s / 8;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    model_clear();
  endtask

  // One sample period: drive, then check avg, spacing, and the following BCD result.
  task automatic sample(input int v);
    int e;
    int n;
    int av;
    model_push(v, e);
    exp_q.push_back(e);
    temperatura = W'(v);
    n = 0;
    while (avg_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (avg_valid !== 1'b1) begin
      bad++;
      $display("FAIL avg_valid_timeout: got %b want 1", avg_valid);
      void'(exp_q.pop_front());
      return;
    end
    if (last_av >= 0) begin
      total++;
      if (cyc - last_av != int'(SAMPLE_DIV)) begin
        bad++;
        $display("FAIL avg_spacing: got %0d want %0d", cyc - last_av, SAMPLE_DIV);
      end
    end
    last_av = cyc;
    av      = cyc;
    e       = exp_q.pop_front();
    total++;
    if (avg !== W'(e)) begin
      bad++;
      $display("FAIL avg_value: got %0d want %0d", avg, e);
    end
    step();
    total++;
    if (avg_valid !== 1'b0) begin
      bad++;
      $display("FAIL avg_valid_pulse: got %b want 0", avg_valid);
    end
    n = 0;
    while (bcd_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bcd_valid !== 1'b1) begin
      bad++;
      $display("FAIL bcd_valid_timeout: got %b want 1", bcd_valid);
      return;
    end
    total++;
    if (cyc - av != 11) begin
      bad++;
      $display("FAIL bcd_latency: got %0d want 11", cyc - av);
    end
    total++;
    if ({bcd_hund, bcd_tens, bcd_ones} !== {4'(e / 100), 4'((e / 10) % 10), 4'(e % 10)}) begin
      bad++;
      $display("FAIL bcd_digits: got %0d%0d%0d want %0d", bcd_hund, bcd_tens, bcd_ones, e);
    end
    step();
  endtask

  task automatic test_reset();
    temperatura = 9'd300;
    do_reset(2);
    total++;
    if ({avg, avg_valid, filled, bcd_hund, bcd_tens, bcd_ones, bcd_valid} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {avg, avg_valid, filled, bcd_hund, bcd_tens, bcd_ones, bcd_valid});
    end
  endtask

  // Cycle-exact check of the first sample after reset.
  task automatic test_first_sample();
    int e;
    do_reset(2);
    temperatura = 9'd25;
    model_push(25, e);
    exp_q.push_back(e);
    for (int k = 0; k < 30; k++) begin
      total++;
      if (filled !== logic'(k >= 16)) begin
        bad++;
        $display("FAIL first_filled: cycle %0d got %b want %b", k, filled, k >= 16);
      end
      total++;
      if (avg_valid !== logic'(k == 17)) begin
        bad++;
        $display("FAIL first_avg_valid: cycle %0d got %b want %b", k, avg_valid, k == 17);
      end
      total++;
      if (bcd_valid !== logic'(k == 28)) begin
        bad++;
        $display("FAIL first_bcd_valid: cycle %0d got %b want %b", k, bcd_valid, k == 28);
      end
      if (k == 17) begin
        e = exp_q.pop_front();
        last_av = cyc;
        total++;
        if (avg !== W'(e)) begin
          bad++;
          $display("FAIL first_avg: got %0d want %0d", avg, e);
        end
      end
      if (k == 28) begin
        total++;
        if ({bcd_hund, bcd_tens, bcd_ones} !== 12'h025) begin
          bad++;
          $display("FAIL first_bcd: got %0d%0d%0d want 025", bcd_hund, bcd_tens, bcd_ones);
        end
      end
      step();
    end
  endtask

  task automatic test_step();
    sample(25);
    for (int i = 0; i < 8; i++) sample(33);
  endtask

  task automatic test_max();
    do_reset(1);
    sample(511);
    sample(511);
  endtask

  task automatic test_truncation();
    do_reset(1);
    sample(0);
    sample(7);
    sample(7);
  endtask

  task automatic test_reset_mid_shift();
    int n;
    temperatura = 9'd100;
    n = 0;
    while (avg_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (avg_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_avg_timeout: got %b want 1", avg_valid);
    end
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    total++;
    if ({avg, avg_valid, filled, bcd_hund, bcd_tens, bcd_ones, bcd_valid} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got %h want 0",
               {avg, avg_valid, filled, bcd_hund, bcd_tens, bcd_ones, bcd_valid});
    end
    for (int k = 0; k < 14; k++) begin
      total++;
      if (bcd_valid !== 1'b0 || avg_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_no_pulse: cycle %0d got %b%b want 00", k, avg_valid, bcd_valid);
      end
      step();
    end
    // 64 preloads the window, so one 0 afterwards gives 7*64/8 = 56.
    sample(64);
    sample(0);
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_step();
    test_max();
    test_truncation();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
